mole_hit_scorer: RTL and testbench

MOLE_HIT_SCORER -- requirements
Module: mole_hit_scorer

---
 rtl/mole_hit_scorer.sv | 144 ++++++++++++++
 tb/tb_mole_hit_scorer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scoring core: synchronises slide switches, turns toggles into
// hits/misses against the lit mole pattern, and keeps a saturating score.
module mole_hit_scorer #(
  parameter int unsigned N_MOLES      = 18,
  parameter int unsigned SCORE_MAX    = 9999,
  parameter int unsigned MISS_PENALTY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         level,
  input  logic               spawn,
  input  logic [N_MOLES-1:0] mole_mask,
  input  logic [N_MOLES-1:0] switches,
  output logic [N_MOLES-1:0] active_mask,
  output logic [13:0]        score,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               round_clear,
  output logic               playing
);

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned CNT_W   = $clog2(N_MOLES + 1);
  localparam int unsigned SUM_W   = 24;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_t;

  state_t               state_q, state_d;
  logic [N_MOLES-1:0]   sync1_q, sync2_q, prev_q;
  logic [N_MOLES-1:0]   mask_q, mask_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 clr_q, clr_d;
  logic                 playing_q, playing_d;

  logic [N_MOLES-1:0]   toggle;
  logic [N_MOLES-1:0]   hit_vec, miss_vec;
  logic [CNT_W-1:0]     hit_cnt, miss_cnt;
  logic [SUM_W-1:0]     gain_u, loss_u;
  logic signed [SUM_W-1:0] sum_s;
  logic [SCORE_W-1:0]   score_sat;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_MOLES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N_MOLES); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Hit/miss classification and saturating score arithmetic for one update
  always_comb begin
    toggle    = sync2_q ^ prev_q;
    hit_vec   = toggle & mask_q;
    miss_vec  = toggle & ~mask_q;
    hit_cnt   = popcount(hit_vec);
    miss_cnt  = popcount(miss_vec);
    gain_u    = SUM_W'(hit_cnt) * (SUM_W'(level) + SUM_W'(1));
    loss_u    = SUM_W'(miss_cnt) * SUM_W'(MISS_PENALTY);
    sum_s     = $signed(SUM_W'(score_q)) + $signed(gain_u) - $signed(loss_u);
    score_sat = SCORE_W'(sum_s);
    if (sum_s[SUM_W-1]) begin
      score_sat = '0;
    end else if (sum_s > $signed(SUM_W'(SCORE_MAX))) begin
      score_sat = SCORE_W'(SCORE_MAX);
    end
  end

  // Game FSM: next state, mask, score and pulses
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mask_d = '0;
        if (start && !stop) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          mask_d  = '0;
        end else if (spawn) begin
          mask_d = mole_mask;
        end else begin
          mask_d  = mask_q & ~hit_vec;
          score_d = score_sat;
          hit_d   = |hit_vec;
          miss_d  = |miss_vec;
          clr_d   = (mask_q != '0) && ((mask_q & ~hit_vec) == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
    playing_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      mask_q    <= '0;
      score_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      clr_q     <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= switches;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      mask_q    <= mask_d;
      score_q   <= score_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      clr_q     <= clr_d;
      playing_q <= playing_d;
    end
  end

  assign active_mask = mask_q;
  assign score       = score_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign round_clear = clr_q;
  assign playing     = playing_q;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed scoreboard bench for mole_hit_scorer: expectations are queued as
// stimulus is applied and compared against the registered outputs.
module tb_mole_hit_scorer;

  localparam int unsigned N = 18;

  logic         clk = 1'b0;
  logic         reset, start, stop, spawn;
  logic [1:0]   level;
  logic [N-1:0] mole_mask, switches;
  logic [N-1:0] active_mask;
  logic [13:0]  score;
  logic         hit_pulse, miss_pulse, round_clear, playing;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] mask;
    logic [13:0]  score;
    logic         hit;
    logic         miss;
    logic         clr;
    logic         play;
  } exp_t;

  exp_t sb[$];
  int   m_score;

  mole_hit_scorer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .level       (level),
    .spawn       (spawn),
    .mole_mask   (mole_mask),
    .switches    (switches),
    .active_mask (active_mask),
    .score       (score),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .round_clear (round_clear),
    .playing     (playing)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [N-1:0] m, input int s,
                      input logic h, input logic mi, input logic c, input logic p);
    exp_t e;
    e.tag = tag; e.mask = m; e.score = 14'(s);
    e.hit = h; e.miss = mi; e.clr = c; e.play = p;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "mask",  32'(active_mask), 32'(e.mask));
      chk(e.tag, "score", 32'(score),       32'(e.score));
      chk(e.tag, "hit",   32'(hit_pulse),   32'(e.hit));
      chk(e.tag, "miss",  32'(miss_pulse),  32'(e.miss));
      chk(e.tag, "clr",   32'(round_clear), 32'(e.clr));
      chk(e.tag, "play",  32'(playing),     32'(e.play));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic do_spawn(input logic [N-1:0] m);
    spawn = 1'b1; mole_mask = m; tick(1); spawn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0; spawn = 1'b1;
    level = 2'd0; mole_mask = '1; switches = '0;
    tick(3);
    push("reset", '0, 0, 0, 0, 0, 0); check_out();
    reset = 1'b0; start = 1'b0; spawn = 1'b0;
    tick(2);

    pulse_start();
    push("start", '0, 0, 0, 0, 0, 1); check_out();
    level = 2'd2;
    do_spawn(18'h00005);
    push("spawn5", 18'h00005, 0, 0, 0, 0, 1); check_out();

    // Switch 0 hit: effect lands on the third edge, not before
    switches[0] = ~switches[0];
    tick(2);
    push("hit0_early", 18'h00005, 0, 0, 0, 0, 1); check_out();
    tick(1);
    push("hit0", 18'h00004, 3, 1, 0, 0, 1); check_out();
    tick(1);
    push("hit0_after", 18'h00004, 3, 0, 0, 0, 1); check_out();

    switches[2] = ~switches[2];
    tick(3);
    push("hit2_clear", '0, 6, 1, 0, 1, 1); check_out();
    tick(1);
    push("hit2_after", '0, 6, 0, 0, 0, 1); check_out();

    pulse_start();
    push("start_in_play", '0, 6, 0, 0, 0, 1); check_out();
    pulse_stop();
    push("stop", '0, 6, 0, 0, 0, 0); check_out();
    pulse_start();
    push("restart", '0, 0, 0, 0, 0, 1); check_out();

    switches[5] = ~switches[5];
    tick(3);
    push("miss_floor", '0, 0, 0, 1, 0, 1); check_out();
    tick(1);
    push("miss_after", '0, 0, 0, 0, 0, 1); check_out();

    // Saturation: 18 hits at level 3 give +72 per round
    level = 2'd3;
    m_score = 0;
    for (int r = 0; r < 141; r++) begin
      do_spawn('1);
      switches = ~switches;
      tick(3);
      m_score = (m_score + 72 > 9999) ? 9999 : m_score + 72;
      push("sat_round", '0, m_score, 1, 0, 1, 1); check_out();
    end

    pulse_stop();
    pulse_start();
    push("restart2", '0, 0, 0, 0, 0, 1); check_out();
    level = 2'd2;
    do_spawn(18'h00001);
    switches[0] = ~switches[0];
    tick(3);
    push("hit_lvl2", '0, 3, 1, 0, 1, 1); check_out();

    level = 2'd0;
    do_spawn(18'h00001);
    switches[1:0] = ~switches[1:0];
    tick(3);
    push("hit_and_miss", '0, 3, 1, 1, 1, 1); check_out();

    // Toggle reaches the update stage in the same cycle as a spawn
    switches[4] = ~switches[4];
    tick(2);
    do_spawn(18'h00030);
    push("spawn_discard", 18'h00030, 3, 0, 0, 0, 1); check_out();
    tick(2);
    push("spawn_discard_after", 18'h00030, 3, 0, 0, 0, 1); check_out();

    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    push("start_stop_play", '0, 3, 0, 0, 0, 0); check_out();
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    push("start_stop_idle", '0, 3, 0, 0, 0, 0); check_out();

    switches[3] = ~switches[3];
    do_spawn(18'h000ff);
    tick(3);
    push("idle_ignore", '0, 3, 0, 0, 0, 0); check_out();

    pulse_start();
    push("start3", '0, 0, 0, 0, 0, 1); check_out();
    do_spawn(18'h00008);
    switches[3] = ~switches[3];
    tick(3);
    push("first_hit", '0, 1, 1, 0, 1, 1); check_out();

    do_spawn(18'h00001);
    switches[0] = ~switches[0];
    tick(1);
    reset = 1'b1; start = 1'b1; tick(1); reset = 1'b0; start = 1'b0;
    push("reset_mid", '0, 0, 0, 0, 0, 0); check_out();
    tick(3);
    push("reset_mid_after", '0, 0, 0, 0, 0, 0); check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
